uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive stage of the UART, directly upstream of the APB register block. It oversamples the asynchronous `Rx` line at 16x the baud rate and majority-votes each bit. It deserializes 8N1 frames, LSB first, and presents each completed byte on `RxData` with a one-cycle `RxDone` strobe. The register block latches `RxData` into its receive buffer on that strobe.

## Interface
Parameters
- `CLK_DIV`, default 54: `pClk` cycles per oversample tick, equal to f_pClk / (16 × baud). Minimum legal value is 2. Counter width is `$clog2(CLK_DIV)`.

Ports
- `pClk`  in  1  system clock.
- `pReset`  in  1  asynchronous, active-low reset.
- `Rx`  in  1  asynchronous serial input; idles high.
- `RxData`  out  8  last correctly framed byte; holds until the next good frame.
- `RxDone`  out  1  one-cycle pulse when `RxData` is updated.
- `FrameErr`  out  1  one-cycle pulse when the stop bit is sampled low.
- `Busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Synchronizer.** Two flops followed by a third delay flop give `rx_s` and `rx_d`. All three reset to 1, so reset never produces a false start. A falling edge is the condition `rx_d=1 & rx_s=0`.
- **Tick generator.** The counter is held at 0 in IDLE and WAIT_HIGH. Otherwise it counts 0..`CLK_DIV-1` and emits `tick` at `CLK_DIV-1`, then wraps.
- **Sample counter.** 4 bits, advances on each `tick` and wraps 15→0; a wrap marks the end of a bit. Samples are captured at sample indices 7, 8 and 9. The vote is the majority of those 3 samples and is evaluated on the tick of index 9.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE:** a falling edge moves the FSM to START and clears the tick, sample and bit counters.
- **START:**
  - Vote at index 9 = 1: false start. Return to IDLE, with no output activity.
  - Vote = 0: continue; at the index-15 tick go to DATA.
- **DATA:**
  - At index 9, shift the vote into bit 7 of the shift register (right shift, so the LSB arrives first).
  - At index 15, increment the bit counter (0..7); after bit 7, go to STOP.
- **STOP:** act at index 9.
  - Vote = 1: `RxData`←shift register, pulse `RxDone`, go to IDLE immediately. The remaining half stop bit is not waited out, which gives margin against baud mismatch.
  - Vote = 0: pulse `FrameErr`, leave `RxData` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH:** go to IDLE when `rx_s`=1. This stops a break condition or a low line from retriggering.
- **Falling edges while not IDLE** are ignored.
- **`RxDone` and `FrameErr`** are mutually exclusive and never assert in the same cycle.
- **No overrun tracking.** The downstream register overwrites its buffer on every `RxDone`.

## Timing
- **Reset values:** `RxData`=8'h00, `RxDone`=0, `FrameErr`=0, `Busy`=0, state IDLE, all counters 0, shift register 0.
- **Reset mid-frame** (`pReset` low at any point) returns everything to reset values at once, with no pulse. After release, the line must show a fresh falling edge before reception restarts.
- **Pin to edge detect:** 3 `pClk` cycles. `Busy` rises in the cycle after edge detect.
- Let E be the edge-detect cycle. Tick k fires at E + k·`CLK_DIV`, where bit = (k−1)/16 and sample index = (k−1) mod 16.
- **Stop decision** is on tick k = 154. `RxDone`, `FrameErr` and the new `RxData` are visible at E + 154·`CLK_DIV` + 1.
- **`Busy`** falls in the same cycle as `RxDone`. On a framing error it falls when the line has returned high.
- **Back-to-back frames:** a start edge arriving one cycle after `RxDone` is accepted.
- **Error tolerance:** at least ±3% cumulative baud error is tolerated. A single corrupted sample among indices 7–9 does not change a bit.

## Test plan
- **Nominal frame:** `CLK_DIV`=4; drive 0xA5 as 8N1 at exactly 64 `pClk` per bit. Expect `RxData`=8'hA5, a single `RxDone` pulse at E+617, and `FrameErr` staying 0.
- **Glitch rejection:** drive `Rx` low for 20 `pClk`, then high. Expect `Busy` to pulse and return to 0, with no `RxDone`, no `FrameErr`, and `RxData` unchanged.
- **Framing error:**
  - Send 0x3C with the stop bit held low and the line kept low for 300 `pClk`.
  - Expect one `FrameErr` pulse, `RxData` keeping its previous value, and `Busy` staying high until the line rises.
  - Then send 0x81. Expect `RxData`=8'h81.
- **Back-to-back frames:** send 0x00 then 0xFF with 1 stop bit and no idle gap. Expect two `RxDone` pulses, with `RxData` reading 00 then FF.
- **Majority voting:** with 0x55, invert `Rx` for exactly one tick period centred on sample index 8 of bit 3. Expect `RxData`=8'h55.
- **Reset mid-frame:** assert `pReset` during bit 4 of a frame. Expect all outputs to return to reset values immediately with no pulse. A subsequent 0x7E frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receive stage: 16x oversampled, majority-voted 8N1 deserializer.
// Delivers each good byte on RxData with a one-cycle RxDone strobe and
// reports a low stop bit as a one-cycle FrameErr strobe.
module uart_rx #(
    parameter int unsigned CLK_DIV = 54
) (
    input  logic       pClk,
    input  logic       pReset,
    input  logic       Rx,
    output logic [7:0] RxData,
    output logic       RxDone,
    output logic       FrameErr,
    output logic       Busy
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]      samp_q, samp_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            s7_q, s7_d;
    logic            s8_q, s8_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_done_q, rx_done_d;
    logic            frame_err_q, frame_err_d;

    // Synchronizer chain; all stages reset high so reset cannot fake a start edge
    logic rx_meta_q, rx_s_q, rx_dly_q;

    logic tick;
    logic vote;
    logic fall;
    logic counting;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_dly_q  <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_s_q    <= rx_meta_q;
            rx_dly_q  <= rx_s_q;
        end
    end

    assign fall     = rx_dly_q & ~rx_s_q;
    assign counting = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
    assign tick     = counting && (tick_cnt_q == CntMax);
    // Majority of samples 7 and 8 with the live sample taken at index 9
    assign vote     = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);

    // State, counter and output registers
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            samp_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            s7_q        <= 1'b0;
            s8_q        <= 1'b0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state: tick/sample counting, sampling, frame FSM and output strobes
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        samp_d      = samp_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        s7_d        = s7_q;
        s8_d        = s8_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        if (tick) begin
            samp_d = samp_q + 4'd1;
            if (samp_q == 4'd7) s7_d = rx_s_q;
            if (samp_q == 4'd8) s8_d = rx_s_q;
        end

        unique case (state_q)
            StIdle: begin
                if (fall) state_d = StStart;
            end
            StStart: begin
                if (tick && (samp_q == 4'd9) && vote) begin
                    state_d = StIdle;
                end else if (tick && (samp_q == 4'd15)) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tick && (samp_q == 4'd9)) begin
                    shift_d = {vote, shift_q[7:1]};
                end
                if (tick && (samp_q == 4'd15)) begin
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            StStop: begin
                // Decide mid stop bit; skipping its second half buys baud margin
                if (tick && (samp_q == 4'd9)) begin
                    if (vote) begin
                        rx_data_d = shift_q;
                        rx_done_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                // A held-low line (break) must not look like a new start bit
                if (rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Counters sit at zero outside a frame and restart cleanly on a start edge
        if ((state_q == StIdle) || (state_q == StWaitHigh) ||
            (state_d == StIdle) || (state_d == StWaitHigh)) begin
            tick_cnt_d = '0;
            samp_d     = '0;
            bit_d      = '0;
        end
    end

    assign RxData   = rx_data_q;
    assign RxDone   = rx_done_q;
    assign FrameErr = frame_err_q;
    assign Busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus hand-written
// corner cases, with a scoreboard queue checked on every RxDone.
module tb_uart_rx;

    localparam int unsigned ClkDiv = 4;
    localparam int BitLen = 16 * ClkDiv;

    logic       pClk = 1'b0;
    logic       pReset = 1'b0;
    logic       Rx = 1'b1;
    logic [7:0] RxData;
    logic       RxDone;
    logic       FrameErr;
    logic       Busy;

    uart_rx #(.CLK_DIV(ClkDiv)) dut (
        .pClk     (pClk),
        .pReset   (pReset),
        .Rx       (Rx),
        .RxData   (RxData),
        .RxDone   (RxDone),
        .FrameErr (FrameErr),
        .Busy     (Busy)
    );

    always #5 pClk = ~pClk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge pClk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int   done_cnt = 0;
    int   ferr_cnt = 0;
    int   busy_rise_cnt = 0;
    int   busy_rise_cyc = 0;
    int   done_cyc = 0;
    logic busy_prev = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic [7:0] exp_data;
        int         exp_done;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor sampled on the falling edge, away from the active edge
    always @(negedge pClk) begin
        if (pReset) begin
            if (Busy && !busy_prev) begin
                busy_rise_cnt++;
                busy_rise_cyc = cyc;
            end
            if (RxDone) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_fall_with_done", Busy, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_done: got %0h expected no pulse", RxData);
                end else begin
                    check("sb_rxdata", RxData, exp_q.pop_front());
                end
            end
            if (FrameErr) begin
                ferr_cnt++;
                check("done_ferr_exclusive", RxDone, 0);
            end
        end
        busy_prev = Busy;
    end

    // Drive the line for n cycles; entered and left at #1 after a rising edge
    task automatic hold(input logic v, input int n);
        Rx = v;
        repeat (n) @(posedge pClk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        if (stop_ok) exp_q.push_back(d);
        hold(1'b0, BitLen);
        for (int i = 0; i < 8; i++) hold(d[i], BitLen);
        if (stop_ok) begin
            hold(1'b1, BitLen);
        end else begin
            hold(1'b0, 200);
            check("busy_during_break", Busy, 1);
            hold(1'b0, 100);
            hold(1'b1, 1);
        end
    endtask

    logic [7:0] last_good;
    int d0, f0, b0;

    initial begin
        vecs[0] = '{data: 8'h3C, stop_ok: 1'b0, exp_data: 8'hA5, exp_done: 0, exp_ferr: 1};
        vecs[1] = '{data: 8'h81, stop_ok: 1'b1, exp_data: 8'h81, exp_done: 1, exp_ferr: 0};
        vecs[2] = '{data: 8'hC3, stop_ok: 1'b1, exp_data: 8'hC3, exp_done: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'h0F, stop_ok: 1'b1, exp_data: 8'h0F, exp_done: 1, exp_ferr: 0};

        // Reset values
        pReset = 1'b0;
        Rx = 1'b1;
        repeat (3) @(posedge pClk);
        #1;
        check("reset_rxdata", RxData, 8'h00);
        check("reset_rxdone", RxDone, 0);
        check("reset_frameerr", FrameErr, 0);
        check("reset_busy", Busy, 0);
        pReset = 1'b1;
        hold(1'b1, 10);

        // Nominal frame with latency check against the edge-detect cycle
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        hold(1'b1, BitLen);
        check("nominal_done_count", done_cnt - d0, 1);
        check("nominal_ferr_count", ferr_cnt - f0, 0);
        check("nominal_rxdata", RxData, 8'hA5);
        check("nominal_latency", done_cyc - (busy_rise_cyc - 1), 617);
        last_good = 8'hA5;

        // Table: framing error then good frames
        for (int i = 0; i < 4; i++) begin
            d0 = done_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_ok);
            hold(1'b1, BitLen);
            check("vec_done_count", done_cnt - d0, vecs[i].exp_done);
            check("vec_ferr_count", ferr_cnt - f0, vecs[i].exp_ferr);
            check("vec_rxdata", RxData, vecs[i].exp_data);
            check("vec_busy_idle", Busy, 0);
            if (vecs[i].stop_ok) last_good = vecs[i].data;
        end

        // Glitch shorter than half a bit is rejected as a false start
        d0 = done_cnt;
        f0 = ferr_cnt;
        b0 = busy_rise_cnt;
        hold(1'b0, 20);
        hold(1'b1, 200);
        check("glitch_busy_pulsed", busy_rise_cnt - b0, 1);
        check("glitch_busy_idle", Busy, 0);
        check("glitch_no_done", done_cnt - d0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check("glitch_rxdata", RxData, last_good);

        // Back-to-back frames with no idle gap
        d0 = done_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, BitLen);
        check("b2b_done_count", done_cnt - d0, 2);
        check("b2b_rxdata", RxData, 8'hFF);
        last_good = 8'hFF;

        // One inverted tick centred on sample 8 of bit 3 is outvoted
        d0 = done_cnt;
        exp_q.push_back(8'h55);
        hold(1'b0, BitLen);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                hold(1'b0, 34);
                hold(1'b1, ClkDiv);
                hold(1'b0, BitLen - 34 - ClkDiv);
            end else begin
                hold(((8'h55 >> i) & 8'h01) != 0, BitLen);
            end
        end
        hold(1'b1, BitLen);
        hold(1'b1, BitLen);
        check("vote_done_count", done_cnt - d0, 1);
        check("vote_rxdata", RxData, 8'h55);

        // Reset during bit 4 aborts the frame with no pulse
        d0 = done_cnt;
        f0 = ferr_cnt;
        hold(1'b0, BitLen);
        for (int i = 0; i < 4; i++) hold(((8'hA5 >> i) & 8'h01) != 0, BitLen);
        hold(1'b0, 32);
        check("pre_reset_busy", Busy, 1);
        pReset = 1'b0;
        Rx = 1'b1;
        #1;
        check("midreset_rxdata", RxData, 8'h00);
        check("midreset_rxdone", RxDone, 0);
        check("midreset_frameerr", FrameErr, 0);
        check("midreset_busy", Busy, 0);
        repeat (3) @(posedge pClk);
        #1;
        pReset = 1'b1;
        hold(1'b1, 100);
        check("midreset_no_done", done_cnt - d0, 0);
        check("midreset_no_ferr", ferr_cnt - f0, 0);
        check("midreset_idle", Busy, 0);
        send_frame(8'h7E, 1'b1);
        hold(1'b1, BitLen);
        check("post_reset_done_count", done_cnt - d0, 1);
        check("post_reset_rxdata", RxData, 8'h7E);

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
